// File: rtl/gpu_core.sv
// APB-fed Bresenham line rasteriser: takes SET_XY1/SET_XY2/DRAW commands and
// streams one pixel per clock with a data_avail strobe, with a one-deep DRAW queue.
module gpu_core #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [31:0]             pAddr_i,
    input  logic [31:0]             pDataWrite_i,
    input  logic                    pSel_i,
    input  logic                    pEnable_i,
    input  logic                    pWrite_i,
    output logic [WIDTH_BITS-1:0]   x_o,
    output logic [HEIGHT_BITS-1:0]  y_o,
    output logic [CHANNEL_BITS-1:0] r_o,
    output logic [CHANNEL_BITS-1:0] g_o,
    output logic [CHANNEL_BITS-1:0] b_o,
    output logic                    data_avail
);

    localparam int EW = 12;

    typedef enum logic {IDLE, DRAWING} state_t;
    state_t state, state_next;

    logic                    acc, acc_q, wr_stb;
    logic [3:0]              opcode;
    logic                    cmd_xy1, cmd_xy2, cmd_draw;
    logic                    unused_bits;

    logic [WIDTH_BITS-1:0]   x1, x2, end_x;
    logic [HEIGHT_BITS-1:0]  y1, y2, end_y;
    logic [WIDTH_BITS-1:0]   dx;
    logic [HEIGHT_BITS-1:0]  dy;
    logic                    sx, sy;
    logic signed [EW-1:0]    err;

    logic                    pend_valid;
    logic [WIDTH_BITS-1:0]   pend_x1, pend_x2;
    logic [HEIGHT_BITS-1:0]  pend_y1, pend_y2;
    logic [CHANNEL_BITS-1:0] pend_r, pend_g, pend_b;

    logic                    last_pix, start_new, start_pend, to_slot, step;

    logic [WIDTH_BITS-1:0]   src_x1, src_x2, src_dx;
    logic [HEIGHT_BITS-1:0]  src_y1, src_y2, src_dy;
    logic [CHANNEL_BITS-1:0] src_r, src_g, src_b;
    logic signed [EW-1:0]    src_err;

    logic signed [EW:0]      e2, dx_ext, dy_ext, err_ext, err_upd;
    logic                    step_x, step_y;

    // One command per access: pEnable_i held high does not retrigger.
    assign acc      = pSel_i & pEnable_i & pWrite_i;
    assign wr_stb   = acc & ~acc_q;
    assign opcode   = pDataWrite_i[31:28];
    assign cmd_xy1  = wr_stb && (opcode == 4'b0001);
    assign cmd_xy2  = wr_stb && (opcode == 4'b0010);
    assign cmd_draw = wr_stb && (opcode == 4'b0100);

    assign unused_bits = ^{pAddr_i, pDataWrite_i[27:24]};

    assign last_pix = (x_o == end_x) && (y_o == end_y);

    always_comb begin
        state_next = state;
        start_new  = 1'b0;
        start_pend = 1'b0;
        to_slot    = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    start_pend = 1'b1;
                    state_next = DRAWING;
                end else if (cmd_draw) begin
                    start_new  = 1'b1;
                    state_next = DRAWING;
                end
            end
            DRAWING: begin
                if (last_pix) begin
                    if (pend_valid)     start_pend = 1'b1;
                    else if (cmd_draw)  start_new  = 1'b1;
                    else                state_next = IDLE;
                end else begin
                    step    = 1'b1;
                    to_slot = cmd_draw && !pend_valid;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        src_x1  = start_pend ? pend_x1 : x1;
        src_y1  = start_pend ? pend_y1 : y1;
        src_x2  = start_pend ? pend_x2 : x2;
        src_y2  = start_pend ? pend_y2 : y2;
        src_r   = start_pend ? pend_r  : pDataWrite_i[23:16];
        src_g   = start_pend ? pend_g  : pDataWrite_i[15:8];
        src_b   = start_pend ? pend_b  : pDataWrite_i[7:0];
        src_dx  = (src_x2 >= src_x1) ? src_x2 - src_x1 : src_x1 - src_x2;
        src_dy  = (src_y2 >= src_y1) ? src_y2 - src_y1 : src_y1 - src_y2;
        src_err = $signed(EW'(src_dx)) - $signed(EW'(src_dy));
    end

    always_comb begin
        e2      = {err, 1'b0};
        dx_ext  = $signed((EW+1)'(dx));
        dy_ext  = $signed((EW+1)'(dy));
        err_ext = {err[EW-1], err};
        step_x  = e2 > -dy_ext;
        step_y  = e2 < dx_ext;
        err_upd = err_ext - (step_x ? dy_ext : '0) + (step_y ? dx_ext : '0);
    end

    always_ff @(posedge clk) begin
        if (n_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            acc_q      <= 1'b0;
            x1         <= '0;
            y1         <= '0;
            x2         <= '0;
            y2         <= '0;
            pend_valid <= 1'b0;
            pend_x1    <= '0;
            pend_y1    <= '0;
            pend_x2    <= '0;
            pend_y2    <= '0;
            pend_r     <= '0;
            pend_g     <= '0;
            pend_b     <= '0;
            end_x      <= '0;
            end_y      <= '0;
            dx         <= '0;
            dy         <= '0;
            sx         <= 1'b0;
            sy         <= 1'b0;
            err        <= '0;
            x_o        <= '0;
            y_o        <= '0;
            r_o        <= '0;
            g_o        <= '0;
            b_o        <= '0;
            data_avail <= 1'b0;
        end else begin
            acc_q <= acc;
            if (cmd_xy1) begin
                x1 <= pDataWrite_i[WIDTH_BITS-1:0];
                y1 <= pDataWrite_i[WIDTH_BITS +: HEIGHT_BITS];
            end
            if (cmd_xy2) begin
                x2 <= pDataWrite_i[WIDTH_BITS-1:0];
                y2 <= pDataWrite_i[WIDTH_BITS +: HEIGHT_BITS];
            end

            if (start_pend) begin
                pend_valid <= 1'b0;
            end else if (to_slot) begin
                pend_valid <= 1'b1;
                pend_x1    <= x1;
                pend_y1    <= y1;
                pend_x2    <= x2;
                pend_y2    <= y2;
                pend_r     <= pDataWrite_i[23:16];
                pend_g     <= pDataWrite_i[15:8];
                pend_b     <= pDataWrite_i[7:0];
            end

            if (start_new || start_pend) begin
                x_o   <= src_x1;
                y_o   <= src_y1;
                r_o   <= src_r;
                g_o   <= src_g;
                b_o   <= src_b;
                end_x <= src_x2;
                end_y <= src_y2;
                dx    <= src_dx;
                dy    <= src_dy;
                sx    <= src_x2 >= src_x1;
                sy    <= src_y2 >= src_y1;
                err   <= src_err;
            end else if (step) begin
                if (step_x) x_o <= sx ? x_o + WIDTH_BITS'(1)  : x_o - WIDTH_BITS'(1);
                if (step_y) y_o <= sy ? y_o + HEIGHT_BITS'(1) : y_o - HEIGHT_BITS'(1);
                err <= err_upd[EW-1:0];
            end

            data_avail <= (state_next == DRAWING);
        end
    end

endmodule

// File: tb/tb_gpu_core.sv
// Randomised and directed bench for gpu_core against a pixel-list reference model.
module tb_gpu_core;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] pAddr_i, pDataWrite_i;
    logic        pSel_i, pEnable_i, pWrite_i;
    logic [9:0]  x_o;
    logic [8:0]  y_o;
    logic [7:0]  r_o, g_o, b_o;
    logic        data_avail;

    always #5 clk = ~clk;

    gpu_core #(.WIDTH_BITS(10), .HEIGHT_BITS(9), .CHANNEL_BITS(8)) dut (
        .clk(clk), .n_rst(n_rst), .pAddr_i(pAddr_i), .pDataWrite_i(pDataWrite_i),
        .pSel_i(pSel_i), .pEnable_i(pEnable_i), .pWrite_i(pWrite_i),
        .x_o(x_o), .y_o(y_o), .r_o(r_o), .g_o(g_o), .b_o(b_o), .data_avail(data_avail)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    int   checks = 0;
    int   errors = 0;
    int   avail_count = 0;

    // Reference model: a line is just the list of pixels it will emit.
    pix_t cur_q[$];
    pix_t pend_q[$];
    pix_t line_q[$];
    bit   pend_valid;
    pix_t last;
    int   mx1, my1, mx2, my2;
    bit   prev_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void build_line(input int x1, input int y1, input int x2, input int y2,
                                       input logic [23:0] col);
        int x, y, dx, dy, sx, sy, err, e2;
        pix_t p;
        line_q.delete();
        x = x1; y = y1;
        dx = (x2 > x1) ? x2 - x1 : x1 - x2;
        dy = (y2 > y1) ? y2 - y1 : y1 - y2;
        sx = (x2 >= x1) ? 1 : -1;
        sy = (y2 >= y1) ? 1 : -1;
        err = dx - dy;
        for (int n = 0; n < 2000; n++) begin
            p.x = x[9:0]; p.y = y[8:0];
            p.r = col[23:16]; p.g = col[15:8]; p.b = col[7:0];
            line_q.push_back(p);
            if (x == x2 && y == y2) break;
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; x += sx; end
            if (e2 < dx)  begin err += dx; y += sy; end
        end
    endfunction

    task automatic model_edge();
        bit       acc, stb, draw, fin;
        bit [3:0] op;
        acc = pSel_i && pEnable_i && pWrite_i;
        stb = acc && !prev_acc;
        prev_acc = acc;
        if (n_rst) begin
            cur_q.delete(); pend_q.delete(); pend_valid = 0;
            last = '0; prev_acc = 0;
            mx1 = 0; my1 = 0; mx2 = 0; my2 = 0;
            return;
        end
        op = pDataWrite_i[31:28];
        draw = stb && op == 4'b0100;
        if (draw) build_line(mx1, my1, mx2, my2, pDataWrite_i[23:0]);
        if (cur_q.size() > 0) begin
            fin = cur_q.size() == 1;
            void'(cur_q.pop_front());
            if (fin) begin
                if (pend_valid) begin cur_q = pend_q; pend_valid = 0; end
                else if (draw) cur_q = line_q;
            end else if (draw && !pend_valid) begin
                pend_q = line_q; pend_valid = 1;
            end
        end else if (draw) begin
            cur_q = line_q;
        end
        if (stb && op == 4'b0001) begin mx1 = pDataWrite_i[9:0]; my1 = pDataWrite_i[18:10]; end
        if (stb && op == 4'b0010) begin mx2 = pDataWrite_i[9:0]; my2 = pDataWrite_i[18:10]; end
        if (cur_q.size() > 0) last = cur_q[0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("data_avail", 64'(data_avail), 64'(cur_q.size() > 0));
        check("pixel", 64'({x_o, y_o, r_o, g_o, b_o}), 64'(last));
        if (data_avail) avail_count++;
    endtask

    task automatic apb_write(input logic [31:0] d, input int hold);
        pSel_i = 1; pWrite_i = 1; pEnable_i = 0; pDataWrite_i = d;
        pAddr_i = $urandom;
        tick();
        pEnable_i = 1;
        for (int i = 0; i < hold; i++) tick();
        pSel_i = 0; pEnable_i = 0; pWrite_i = 0;
    endtask

    function automatic logic [31:0] xy(input logic [3:0] op, input int x, input int y);
        logic [9:0] xv;
        logic [8:0] yv;
        xv = x[9:0]; yv = y[8:0];
        return {op, 9'd0, yv, xv};
    endfunction

    task automatic drain(input string tag, input int bound);
        int i;
        i = 0;
        while ((cur_q.size() > 0 || data_avail) && i < bound) begin
            tick();
            i++;
        end
        check(tag, 64'(i < bound), 64'd1);
    endtask

    task automatic draw_line(input int x1, input int y1, input int x2, input int y2);
        apb_write(xy(4'b0001, x1, y1), 1);
        apb_write(xy(4'b0010, x2, y2), 1);
        apb_write({4'b0100, 4'h0, 24'($urandom)}, 1);
    endtask

    initial begin
        int i;
        logic [3:0] ops [4];
        ops[0] = 4'b0001; ops[1] = 4'b0010; ops[2] = 4'b0100; ops[3] = 4'b1000;
        pAddr_i = '0; pDataWrite_i = '0; pSel_i = 0; pEnable_i = 0; pWrite_i = 0;
        n_rst = 1;
        tick(); tick();
        n_rst = 0;
        check("reset_outputs", 64'({data_avail, x_o, y_o, r_o, g_o, b_o}), 64'd0);
        tick();

        // Two back-to-back lines, second queued while the first is drawing
        avail_count = 0;
        apb_write(32'h1000_0000, 1);
        apb_write(32'h2002_A4C8, 1);
        apb_write(32'h40AA_BD3E, 1);
        check("line1_first", 64'({x_o, y_o, r_o, g_o, b_o}), 64'({10'd0, 9'd0, 8'd170, 8'd189, 8'd62}));
        apb_write(xy(4'b0001, 200, 169), 1);
        apb_write(32'h2003_C000, 1);
        apb_write(32'h40AA_BD3E, 1);
        drain("line12_timeout", 1000);
        check("line12_count", 64'(avail_count), 64'd402);
        check("line12_last", 64'({x_o, y_o}), 64'({10'd0, 9'd240}));

        // Degenerate, horizontal, vertical
        avail_count = 0;
        draw_line(5, 5, 5, 5);
        drain("degen_timeout", 50);
        check("degen_count", 64'(avail_count), 64'd1);
        avail_count = 0;
        draw_line(10, 20, 15, 20);
        drain("horiz_timeout", 50);
        check("horiz_count", 64'(avail_count), 64'd6);
        check("horiz_last", 64'({x_o, y_o}), 64'({10'd15, 9'd20}));
        avail_count = 0;
        draw_line(7, 3, 7, 0);
        drain("vert_timeout", 50);
        check("vert_count", 64'(avail_count), 64'd4);
        check("vert_last", 64'({x_o, y_o}), 64'({10'd7, 9'd0}));

        // Unknown opcode, then DRAW with the access phase held three cycles
        avail_count = 0;
        apb_write(32'h8000_1234, 1);
        for (int k = 0; k < 4; k++) tick();
        check("bad_op_count", 64'(avail_count), 64'd0);
        apb_write(xy(4'b0001, 10, 20), 1);
        apb_write(xy(4'b0010, 15, 20), 1);
        apb_write(32'h4012_3456, 3);
        drain("hold_timeout", 50);
        check("hold_count", 64'(avail_count), 64'd6);

        // Reset mid-line discards the line and the pending draw
        avail_count = 0;
        apb_write(32'h1000_0000, 1);
        apb_write(32'h2002_A4C8, 1);
        apb_write(32'h40AA_BD3E, 1);
        apb_write(32'h40AA_BD3E, 1);
        i = 0;
        while (avail_count < 50 && i < 500) begin tick(); i++; end
        check("reset_wait_timeout", 64'(i < 500), 64'd1);
        n_rst = 1;
        tick();
        n_rst = 0;
        check("midreset_outputs", 64'({data_avail, x_o, y_o, r_o, g_o, b_o}), 64'd0);
        avail_count = 0;
        for (int k = 0; k < 10; k++) tick();
        check("midreset_no_pending", 64'(avail_count), 64'd0);
        apb_write(32'h4011_2233, 1);
        drain("postreset_timeout", 50);
        check("postreset_count", 64'(avail_count), 64'd1);

        // Random command mix, including writes and drops while drawing
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            op = ops[$urandom_range(0, 3)];
            if (op == 4'b0100)
                apb_write({op, 4'($urandom), 24'($urandom)}, $urandom_range(1, 3));
            else
                apb_write({op, 9'($urandom), 9'($urandom_range(0, 479)), 10'($urandom_range(0, 639))},
                          $urandom_range(1, 2));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
            if ($urandom_range(0, 7) == 0) drain("rand_drain_timeout", 2000);
        end
        drain("final_timeout", 3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_core.md
Name:
gpu_core

Overview:
- APB-slave-fed 2D line rasteriser.
- The host writes endpoint XY1, endpoint XY2, then a DRAW command carrying an RGB colour.
- The block walks a Bresenham line from XY1 to XY2 inclusive and emits one pixel per clock (x, y, r, g, b) with a data_avail strobe.
- It sits between the APB bus and the frame-buffer/pixel writer.

Parameters:
- WIDTH_BITS, 10, x coordinate width (640-wide screen).
- HEIGHT_BITS, 9, y coordinate width (480-high screen).
- CHANNEL_BITS, 8, width of each colour channel.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- n_rst  in  1  reset; one clock, synchronous and active-high (asserted = 1 clears state on the next clk edge).
- pAddr_i  in  32  APB address; ignored, single command register.
- pDataWrite_i  in  32  APB write data / command word.
- pSel_i  in  1  APB select.
- pEnable_i  in  1  APB enable (access phase).
- pWrite_i  in  1  APB write.
- x_o  out  WIDTH_BITS  pixel x.
- y_o  out  HEIGHT_BITS  pixel y.
- r_o  out  CHANNEL_BITS  pixel red.
- g_o  out  CHANNEL_BITS  pixel green.
- b_o  out  CHANNEL_BITS  pixel blue.
- data_avail  out  1  high on every cycle the pixel outputs hold a valid pixel.

Behaviour:
- APB write accept:
  - A write is accepted on a clk edge where pSel_i=1, pEnable_i=1 and pWrite_i=1.
  - Exactly one command is taken per access, even if pEnable_i stays high for several cycles (edge-detect on the access phase).
  - No wait states; reads are unsupported.
- Command word:
  - opcode = pDataWrite_i[31:28].
  - 4'b0001 SET_XY1: x1 = [9:0], y1 = [18:10].
  - 4'b0010 SET_XY2: x2 = [9:0], y2 = [18:10].
  - 4'b0100 DRAW: r = [23:16], g = [15:8], b = [7:0].
  - Any other opcode is ignored.
- XY1/XY2 registers:
  - Writable at any time, including during a draw.
  - DRAW snapshots x1, y1, x2, y2 and the colour, so later writes never disturb a line in flight.
- Command queue:
  - One-deep pending DRAW slot.
  - DRAW while IDLE: the line starts at once.
  - DRAW while DRAWING with the slot empty: the snapshot goes to the slot and starts the cycle after the current line's last pixel (no gap).
  - DRAW while DRAWING with the slot full: the new DRAW is dropped.
- FSM states:
  - IDLE -> DRAWING on an accepted DRAW or a pending slot.
  - DRAWING -> IDLE after the final pixel, when no draw is pending.
- Latency: the first pixel (x1, y1) appears with data_avail=1 in the cycle after the edge that accepted DRAW.
- Pixel count and order:
  - data_avail stays high for exactly max(|dx|, |dy|) + 1 consecutive cycles.
  - The last pixel is (x2, y2).
  - A degenerate line (XY1 == XY2) emits exactly 1 pixel.
- Bresenham algorithm:
  - dx = |x2 - x1|, dy = |y2 - y1|; sx, sy = ±1 toward the end point.
  - err = dx - dy, 12-bit signed.
  - Each step: e2 = 2*err. If e2 > -dy: err -= dy, x += sx. If e2 < dx: err += dx, y += sy.
  - Lines must be correct in all octants, including horizontal and vertical lines.
- Colour: r_o, g_o, b_o carry the line colour for every pixel of that line.
- No clipping; coordinates are used as written.
- Outputs:
  - When idle, all outputs hold the last pixel and data_avail = 0.
  - Reset value of all outputs is 0, with data_avail = 0.
- Reset behaviour:
  - Clears x1, y1, x2, y2 and the pending slot, and goes to IDLE.
  - Reset asserted mid-line aborts the line; data_avail = 0 from the next edge.

Test Plan:
- SET_XY1 0x1000_0000, SET_XY2 0x2002_A4C8 (200,169), DRAW 0x40AA_BD3E -> 201 pixels from (0,0) to (200,169); every pixel r=170, g=189, b=62; data_avail contiguous.
- Immediately after that, during drawing: SET_XY1 (200,169), SET_XY2 0x2003_C000 (0,240), DRAW 0x40AA_BD3E -> the second line starts the cycle after pixel (200,169); 201 pixels ending (0,240); the first line is unaffected.
- XY1 = XY2 = (5,5), DRAW -> exactly 1 pixel at (5,5), then data_avail = 0.
- Horizontal (10,20)->(15,20) and vertical (7,3)->(7,0) -> 6 pixels with x incrementing, and 4 pixels with y decrementing.
- Opcode 4'b1000 write, and an access with pEnable_i held high 3 cycles -> no effect / exactly one command taken.
- Reset asserted at pixel 50 of the first line -> data_avail = 0 and outputs 0 next cycle; the pending draw is discarded.
